// File: rtl/dsi_hs_lane_rx_if.sv
// Lane-side bundle between the HS deserializer/LP detector and the aligned-byte consumer.
interface dsi_hs_lane_rx_if;
  logic       hs_active;
  logic       raw_valid;
  logic [7:0] raw_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       sync_det;
  logic       sync_err;
  logic       burst_end;
  logic [2:0] align_offset;
  logic       busy;

  modport master (
    output hs_active, raw_valid, raw_data,
    input  out_valid, out_data, out_sop, sync_det, sync_err, burst_end, align_offset, busy
  );

  modport slave (
    input  hs_active, raw_valid, raw_data,
    output out_valid, out_data, out_sop, sync_det, sync_err, burst_end, align_offset, busy
  );
endinterface

// File: rtl/dsi_hs_lane_rx.sv
// DSI HS lane receiver: hunts the sync byte at any bit offset, then emits byte-aligned
// payload while holding back the last TRAIL_BYTES bytes of each burst (HS-trail).
//   state  | meaning
//   IDLE   | lane in LP, waiting for hs_active
//   HUNT   | searching the 16-bit window for the sync byte
//   ACTIVE | locked, aligning and delaying payload through the trail FIFO
//   FLUSH  | one cycle: drop trail bytes, pulse burst_end
//   ERROR  | sync timeout, silent until hs_active falls
module dsi_hs_lane_rx #(
  parameter int         TRAIL_BYTES  = 2,
  parameter int         SYNC_TIMEOUT = 16,
  parameter logic [7:0] SYNC_PATTERN = 8'b0001_1101
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  dsi_hs_lane_rx_if.slave lane
);
  typedef enum logic [2:0] {S_IDLE, S_HUNT, S_ACTIVE, S_FLUSH, S_ERROR} state_e;

  localparam int            CW   = $clog2(TRAIL_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(TRAIL_BYTES);
  localparam logic [7:0]    TMO  = 8'(SYNC_TIMEOUT);

  state_e        state_q, state_d;
  logic [7:0]    prev_q;
  logic [7:0]    hunt_cnt_q, hunt_cnt_d;
  logic [7:0]    fifo_q [TRAIL_BYTES];
  logic [7:0]    fifo_d [TRAIL_BYTES];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sop_pend_q, sop_pend_d;
  logic [2:0]    offset_q, offset_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_sop_q, out_sop_d;
  logic          sync_det_q, sync_det_d;
  logic          sync_err_q, sync_err_d;
  logic          burst_end_q, burst_end_d;

  logic [15:0]   window;
  logic [3:0]    msb_idx;
  logic [7:0]    aligned;
  logic          match;
  logic [2:0]    match_k;

  assign window  = {prev_q, lane.raw_data};
  assign msb_idx = 4'd15 - {1'b0, offset_q};
  assign aligned = window[msb_idx -: 8];

  // Scan from the highest offset down so the lowest matching offset wins.
  always_comb begin
    match   = 1'b0;
    match_k = '0;
    for (int k = 7; k >= 0; k--) begin
      if (window[15-k -: 8] == SYNC_PATTERN) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hunt_cnt_d  = hunt_cnt_q;
    fifo_d      = fifo_q;
    cnt_d       = cnt_q;
    sop_pend_d  = sop_pend_q;
    offset_d    = offset_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sop_d   = 1'b0;
    sync_det_d  = 1'b0;
    sync_err_d  = 1'b0;
    burst_end_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lane.hs_active) begin
          state_d    = S_HUNT;
          hunt_cnt_d = '0;
        end
      end
      S_HUNT: begin
        if (!lane.hs_active) begin
          state_d = S_IDLE;
        end else if (lane.raw_valid) begin
          if (match) begin
            state_d    = S_ACTIVE;
            offset_d   = match_k;
            sync_det_d = 1'b1;
            sop_pend_d = 1'b1;
            cnt_d      = '0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + 8'd1;
            if (hunt_cnt_d == TMO) begin
              state_d    = S_ERROR;
              sync_err_d = 1'b1;
            end
          end
        end
      end
      S_ACTIVE: begin
        if (!lane.hs_active) begin
          state_d     = S_FLUSH;
          burst_end_d = 1'b1;
        end else if (lane.raw_valid) begin
          if (cnt_q == FULL) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_q[0];
            out_sop_d   = sop_pend_q;
            sop_pend_d  = 1'b0;
            for (int i = 0; i < TRAIL_BYTES - 1; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[TRAIL_BYTES-1] = aligned;
          end else begin
            fifo_d[cnt_q] = aligned;
            cnt_d         = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        cnt_d      = '0;
        hunt_cnt_d = '0;
        state_d    = lane.hs_active ? S_HUNT : S_IDLE;
      end
      S_ERROR: begin
        if (!lane.hs_active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prev_q      <= '0;
      hunt_cnt_q  <= '0;
      cnt_q       <= '0;
      sop_pend_q  <= 1'b0;
      offset_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      sync_det_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      burst_end_q <= 1'b0;
      for (int i = 0; i < TRAIL_BYTES; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      if (lane.raw_valid) prev_q <= lane.raw_data;
      hunt_cnt_q  <= hunt_cnt_d;
      cnt_q       <= cnt_d;
      sop_pend_q  <= sop_pend_d;
      offset_q    <= offset_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      sync_det_q  <= sync_det_d;
      sync_err_q  <= sync_err_d;
      burst_end_q <= burst_end_d;
      fifo_q      <= fifo_d;
    end
  end

  assign lane.out_valid    = out_valid_q;
  assign lane.out_data     = out_data_q;
  assign lane.out_sop      = out_sop_q;
  assign lane.sync_det     = sync_det_q;
  assign lane.sync_err     = sync_err_q;
  assign lane.burst_end    = burst_end_q;
  assign lane.align_offset = offset_q;
  assign lane.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_dsi_hs_lane_rx.sv
// Bench for dsi_hs_lane_rx: directed scenarios plus random bursts scored against a
// bit-stream reference model (earliest sync position, then every 8th bit after it).
module tb_dsi_hs_lane_rx;
  localparam int TRAIL = 2;
  localparam int TMO   = 16;

  typedef logic [7:0] byte_q_t[$];

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  dsi_hs_lane_rx_if lane ();

  dsi_hs_lane_rx #(.TRAIL_BYTES(TRAIL), .SYNC_TIMEOUT(TMO), .SYNC_PATTERN(8'h1D)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .lane    (lane)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] obs_q[$];
  logic       obs_sop[$];
  int         n_det = 0;
  int         n_err = 0;
  int         n_end = 0;
  logic [2:0] last_off = '0;

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (lane.out_valid) begin
        obs_q.push_back(lane.out_data);
        obs_sop.push_back(lane.out_sop);
      end
      if (lane.sync_det) begin
        n_det    <= n_det + 1;
        last_off <= lane.align_offset;
      end
      if (lane.sync_err)  n_err <= n_err + 1;
      if (lane.burst_end) n_end <= n_end + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic v, input logic [7:0] d);
    @(negedge clk_sys);
    lane.hs_active = hs;
    lane.raw_valid = v;
    lane.raw_data  = d;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":out_valid"}, 32'(lane.out_valid),    32'd0);
    chk({tag, ":out_data"},  32'(lane.out_data),     32'd0);
    chk({tag, ":out_sop"},   32'(lane.out_sop),      32'd0);
    chk({tag, ":sync_det"},  32'(lane.sync_det),     32'd0);
    chk({tag, ":sync_err"},  32'(lane.sync_err),     32'd0);
    chk({tag, ":burst_end"}, 32'(lane.burst_end),    32'd0);
    chk({tag, ":align"},     32'(lane.align_offset), 32'd0);
    chk({tag, ":busy"},      32'(lane.busy),         32'd0);
  endtask

  // Byte starting at serial bit position q of the concatenated word stream.
  function automatic logic [7:0] byte_at(input byte_q_t w, input int q);
    int          i;
    int          k;
    logic [15:0] two;
    i   = q / 8;
    k   = q % 8;
    two = {w[i], (i + 1 < w.size()) ? w[i+1] : 8'h00};
    return two[15-k -: 8];
  endfunction

  // Word 0 is the one seen in IDLE; HUNT words 1..TMO can complete a match, so the
  // search covers bit positions below 8*TMO that end inside the burst.
  function automatic void model(input byte_q_t w, output byte_q_t ex,
                                output int sync, output int err, output int off);
    int L;
    int lim;
    int p;
    int i;
    int m_cnt;
    L    = w.size();
    lim  = 8 * L - 9;
    if (lim > 8 * TMO - 1) lim = 8 * TMO - 1;
    p    = -1;
    ex   = {};
    sync = 0;
    err  = 0;
    off  = 0;
    for (int q = 0; q <= lim; q++) begin
      if (byte_at(w, q) == 8'h1D) begin
        p = q;
        break;
      end
    end
    if (p >= 0) begin
      sync  = 1;
      off   = p % 8;
      i     = p / 8 + 1;
      m_cnt = L - 1 - i;
      for (int m = 1; m <= m_cnt - TRAIL; m++) ex.push_back(byte_at(w, p + 8 * m));
    end else if (L - 1 >= TMO) begin
      err = 1;
    end
  endfunction

  // gap_mode: 0 none, 1 random raw_valid gaps, 2 one 3-cycle gap mid-burst.
  task automatic run_burst(input string tag, input byte_q_t w, input int gap_mode);
    byte_q_t ex;
    int es, ee, eo;
    int b_obs, b_det, b_err, b_end;
    int g;
    model(w, ex, es, ee, eo);
    b_obs = obs_q.size();
    b_det = n_det;
    b_err = n_err;
    b_end = n_end;
    for (int j = 0; j < w.size(); j++) begin
      g = 0;
      if (j > 0 && gap_mode == 1 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
      if (j > 0 && gap_mode == 2 && j == w.size() / 2) g = 3;
      repeat (g) drive(1'b1, 1'b0, 8'($urandom));
      drive(1'b1, 1'b1, w[j]);
    end
    chk({tag, ":busy_hs"}, 32'(lane.busy), 32'd1);
    drive(1'b0, 1'($urandom), 8'($urandom));
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk({tag, ":busy_idle"}, 32'(lane.busy), 32'd0);
    chk({tag, ":sync_det_cnt"}, 32'(n_det - b_det), 32'(es));
    chk({tag, ":sync_err_cnt"}, 32'(n_err - b_err), 32'(ee));
    chk({tag, ":burst_end_cnt"}, 32'(n_end - b_end), 32'(es));
    chk({tag, ":out_count"}, 32'(obs_q.size() - b_obs), 32'(ex.size()));
    if (es != 0) chk({tag, ":align"}, 32'(last_off), 32'(eo));
    for (int m = 0; m < ex.size(); m++) begin
      if (b_obs + m < obs_q.size()) begin
        chk({tag, ":data"}, 32'(obs_q[b_obs+m]), 32'(ex[m]));
        chk({tag, ":sop"}, 32'(obs_sop[b_obs+m]), 32'(m == 0));
      end
    end
  endtask

  initial begin
    byte_q_t    w;
    int         b;
    int         L;
    int         p0;
    logic [7:0] sp;
    logic [7:0] tmp;

    lane.hs_active = 1'b0;
    lane.raw_valid = 1'b0;
    lane.raw_data  = 8'h00;
    #1;
    chk_reset_vals("reset");
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // Offset 0 with exact cycle timing.
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h1D);
    chk("off0:no_det_on_sync_word", 32'(lane.sync_det), 32'd0);
    drive(1'b1, 1'b1, 8'hA5);
    chk("off0:sync_det", 32'(lane.sync_det), 32'd1);
    chk("off0:align", 32'(lane.align_offset), 32'd0);
    drive(1'b1, 1'b1, 8'h3C);
    chk("off0:det_pulse", 32'(lane.sync_det), 32'd0);
    drive(1'b1, 1'b1, 8'hC3);
    chk("off0:no_out_yet", 32'(lane.out_valid), 32'd0);
    drive(1'b1, 1'b1, 8'hFF);
    chk("off0:v1", 32'(lane.out_valid), 32'd1);
    chk("off0:d1", 32'(lane.out_data), 32'hA5);
    chk("off0:sop1", 32'(lane.out_sop), 32'd1);
    drive(1'b1, 1'b1, 8'hFF);
    chk("off0:v2", 32'(lane.out_valid), 32'd1);
    chk("off0:d2", 32'(lane.out_data), 32'h3C);
    chk("off0:sop2", 32'(lane.out_sop), 32'd0);
    drive(1'b0, 1'b1, 8'h00);
    chk("off0:burst_end", 32'(lane.burst_end), 32'd1);
    chk("off0:no_trail_out", 32'(lane.out_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    chk("off0:burst_end_pulse", 32'(lane.burst_end), 32'd0);
    chk("off0:idle", 32'(lane.busy), 32'd0);
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // Offset 3.
    b = obs_q.size();
    run_burst("off3", '{8'h00, 8'h03, 8'hB4, 8'hA7, 8'h5A, 8'hC3, 8'h3C, 8'h11}, 0);
    chk("off3:align_const", 32'(last_off), 32'd3);
    if (obs_q.size() > b) chk("off3:first_byte", 32'(obs_q[b]), 32'hA5);
    else chk("off3:first_byte_missing", 32'(obs_q.size() - b), 32'd1);

    // No sync: 20 zero words.
    w = {};
    repeat (20) w.push_back(8'h00);
    run_burst("nosync", w, 0);

    run_burst("short", '{8'h00, 8'h1D, 8'h42, 8'hE7, 8'hE7}, 0);

    run_burst("gap", '{8'h00, 8'h1D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                       8'h06, 8'h07, 8'h08, 8'h09, 8'h0A}, 2);

    // Async reset with payload in flight, then a clean burst.
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h1D);
    for (int j = 1; j <= 6; j++) drive(1'b1, 1'b1, 8'(j * 17));
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk_sys);
    lane.hs_active = 1'b0;
    lane.raw_valid = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    b = obs_q.size();
    run_burst("post_rst", '{8'h00, 8'h1D, 8'hA5, 8'h3C, 8'hC3, 8'hFF, 8'hFF}, 0);
    if (obs_q.size() > b) chk("post_rst:first_byte", 32'(obs_q[b]), 32'hA5);
    else chk("post_rst:first_byte_missing", 32'(obs_q.size() - b), 32'd1);

    // Random bursts with a sync byte planted at a random bit position most of the time.
    sp = 8'h1D;
    for (int n = 0; n < 40; n++) begin
      w = {};
      L = $urandom_range(2, 24);
      for (int j = 0; j < L; j++) w.push_back(8'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        p0 = $urandom_range(0, 8 * L - 9);
        for (int k = 0; k < 8; k++) begin
          tmp = w[(p0 + k) / 8];
          tmp[7 - ((p0 + k) % 8)] = sp[7 - k];
          w[(p0 + k) / 8] = tmp;
        end
      end
      run_burst("rand", w, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
